// File: rtl/ru_mem_ctrl.sv
// Memory request sequencer: serialises core fetch and load/store onto a single-ported word RAM.
// Optional RU_MEMCTRL_PERF_EN adds saturating stall-cycle and RMW-write counters.
module ru_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    output logic [31:0] d_rdata,
    output logic        stall,
    output logic        fault,
    output logic [31:0] ram_addr,
    output logic        ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
`ifdef RU_MEMCTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_rmw_cnt,
`endif
    input  logic        ram_busy
);

    // state  | meaning
    // IDLE   | waiting for a request; faulting data requests are resolved here
    // DACC   | data RAM cycle: word store, load capture or RMW read
    // RMW    | write back merged word for byte/half store
    // IFETCH | instruction read
    // DONE   | stall released for one cycle, core advances
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DACC,
        ST_RMW,
        ST_IFETCH,
        ST_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] i_rdata_q, d_rdata_q, merge_q;
    logic        fault_q;

    logic        misalign, out_of_range, req_fault, data_req;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext, merged;
    logic        cap_load, cap_merge, cap_fetch, take_fault;
    state_t      after_data;

    always_comb begin
        data_req = d_ren | d_wen;
        case (d_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = d_addr[0];
            2'b10:   misalign = |d_addr[1:0];
            default: misalign = 1'b1;
        endcase
        out_of_range = ({2'b00, d_addr[31:2]} >= MEM_WORDS);
        req_fault    = misalign | out_of_range;
        after_data   = i_req ? ST_IFETCH : ST_DONE;
    end

    always_comb begin
        byte_lane = ram_rdata[{d_addr[1:0], 3'b000} +: 8];
        half_lane = ram_rdata[{d_addr[1], 4'b0000} +: 16];
        case (d_size)
            2'b00:   load_ext = d_unsigned ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = d_unsigned ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_ext = ram_rdata;
        endcase
        merged = merge_q;
        if (d_size == 2'b00) begin
            merged[{d_addr[1:0], 3'b000} +: 8] = d_wdata[7:0];
        end else begin
            merged[{d_addr[1], 4'b0000} +: 16] = d_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stall      = 1'b1;
        ram_addr   = {d_addr[31:2], 2'b00};
        ram_wen    = 1'b0;
        ram_wdata  = merged;
        cap_load   = 1'b0;
        cap_merge  = 1'b0;
        cap_fetch  = 1'b0;
        take_fault = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = i_req | data_req;
                if (data_req) begin
                    if (req_fault) begin
                        take_fault = 1'b1;
                        state_nxt  = after_data;
                    end else begin
                        state_nxt = ST_DACC;
                    end
                end else if (i_req) begin
                    state_nxt = ST_IFETCH;
                end
            end
            ST_DACC: begin
                if (d_wen && d_size == 2'b10) begin
                    ram_wdata = d_wdata;
                end
                if (!ram_busy) begin
                    if (d_wen) begin
                        if (d_size == 2'b10) begin
                            ram_wen   = 1'b1;
                            state_nxt = after_data;
                        end else begin
                            cap_merge = 1'b1;
                            state_nxt = ST_RMW;
                        end
                    end else begin
                        cap_load  = 1'b1;
                        state_nxt = after_data;
                    end
                end
            end
            ST_RMW: begin
                // Write is withheld while busy so exactly one accepted write pulse occurs.
                if (!ram_busy) begin
                    ram_wen   = 1'b1;
                    state_nxt = after_data;
                end
            end
            ST_IFETCH: begin
                ram_addr = {i_addr[31:2], 2'b00};
                if (!ram_busy) begin
                    cap_fetch = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                stall     = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            i_rdata_q <= NOP_INSTR;
            d_rdata_q <= 32'h0;
            merge_q   <= 32'h0;
            fault_q   <= 1'b0;
        end else begin
            // A new request clears any stale fault from the previous access.
            if (state == ST_IDLE && (i_req || data_req)) begin
                fault_q <= take_fault;
            end
            if (take_fault) begin
                d_rdata_q <= 32'h0;
            end else if (cap_load) begin
                d_rdata_q <= load_ext;
            end
            if (cap_merge) begin
                merge_q <= ram_rdata;
            end
            if (cap_fetch) begin
                i_rdata_q <= ram_rdata;
            end
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign fault   = fault_q;

`ifdef RU_MEMCTRL_PERF_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            perf_stall_cnt <= 32'h0;
            perf_rmw_cnt   <= 16'h0;
        end else begin
            if (stall && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (state == ST_RMW && !ram_busy && perf_rmw_cnt != 16'hFFFF) begin
                perf_rmw_cnt <= perf_rmw_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ru_mem_ctrl.sv
// Scoreboard bench for ru_mem_ctrl with a behavioural word RAM and golden memory image.
module tb_ru_mem_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nRst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_ren, d_wen;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_rdata;
    logic        stall, fault;
    logic [31:0] ram_addr;
    logic        ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_busy;
`ifdef RU_MEMCTRL_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_rmw_cnt;
`endif

    always #5 clk = ~clk;

    ru_mem_ctrl dut (
        .clk(clk), .nRst(nRst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_rdata(d_rdata),
        .stall(stall), .fault(fault),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
`ifdef RU_MEMCTRL_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_rmw_cnt(perf_rmw_cnt),
`endif
        .ram_busy(ram_busy)
    );

    // RAM model: combinational read, write on rising edge when not busy
    logic [31:0] mem [256];
    logic [31:0] gold [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;
    int          wen_any;
    int          wen_ok;
    logic [31:0] last_wdata;

    assign ram_rdata = mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (ram_wen) wen_any = wen_any + 1;
        if (ram_wen && !ram_busy) begin
            wen_ok = wen_ok + 1;
            last_wdata = ram_wdata;
            mem[ram_addr[9:2]] <= ram_wdata;
        end
    end

    typedef struct {
        logic [31:0] i_rd;
        logic [31:0] d_rd;
        logic        flt;
        int          stall_cyc;
        int          wen;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          errors;
    logic [31:0] exp_i, exp_d;

    task automatic do_tx(input logic ir, input logic [31:0] ia, input logic rd, input logic wr,
                         input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sz,
                         input logic us, input int busy_len, input string name);
        exp_t        e, g;
        int          cyc, w0, idx, sh;
        logic        flt, dat;
        logic [31:0] w, v, mask;
        dat = rd | wr;
        flt = 1'b0;
        if (dat) begin
            if (sz == 2'b01 && da[0]) flt = 1'b1;
            if (sz == 2'b10 && da[1:0] != 2'b00) flt = 1'b1;
            if (sz == 2'b11) flt = 1'b1;
            if (da >= 32'd1024) flt = 1'b1;
        end
        idx = int'(da[9:2]);
        sh  = (sz == 2'b00) ? 8 * int'(da[1:0]) : 16 * int'(da[1]);
        e.wen   = 0;
        e.wdata = 32'h0;
        if (dat && flt) begin
            exp_d = 32'h0;
        end else if (wr) begin
            w = gold[idx];
            if (sz == 2'b10) begin
                gold[idx] = wd;
            end else begin
                mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
                gold[idx] = (w & ~mask) | ((wd << sh) & mask);
            end
            e.wen   = 1;
            e.wdata = gold[idx];
        end else if (rd) begin
            w = gold[idx];
            if (sz == 2'b00) begin
                v = (w >> sh) & 32'h0000_00FF;
                if (!us && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'b01) begin
                v = (w >> sh) & 32'h0000_FFFF;
                if (!us && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            exp_d = v;
        end
        if (ir) exp_i = gold[ia[9:2]];
        e.i_rd = exp_i;
        e.d_rd = exp_d;
        e.flt  = dat & flt;
        e.stall_cyc = 1 + (ir ? 1 : 0) + ((busy_len > 1) ? busy_len - 1 : 0);
        if (dat && !flt) e.stall_cyc += (wr && sz != 2'b10) ? 2 : 1;
        sb.push_back(e);

        @(negedge clk);
        w0 = wen_any;
        i_req = ir; i_addr = ia; d_ren = rd; d_wen = wr; d_addr = da;
        d_wdata = wd; d_size = sz; d_unsigned = us;
        ram_busy = (busy_len > 0);
        #1;
        cyc = 0;
        while (stall === 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc >= busy_len) ram_busy = 1'b0;
            #1;
        end
        g = sb.pop_front();
        vectors++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: stall still %b after %0d cycles, required 0", name, stall, cyc);
        end
        vectors++;
        if (cyc !== g.stall_cyc) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, cyc, g.stall_cyc);
        end
        vectors++;
        if (i_rdata !== g.i_rd) begin
            errors++;
            $display("FAIL %s i_rdata: got %h, required %h", name, i_rdata, g.i_rd);
        end
        vectors++;
        if (d_rdata !== g.d_rd) begin
            errors++;
            $display("FAIL %s d_rdata: got %h, required %h", name, d_rdata, g.d_rd);
        end
        vectors++;
        if (fault !== g.flt) begin
            errors++;
            $display("FAIL %s fault: got %b, required %b", name, fault, g.flt);
        end
        vectors++;
        if (wen_any - w0 !== g.wen) begin
            errors++;
            $display("FAIL %s ram_wen_cycles: got %0d, required %0d", name, wen_any - w0, g.wen);
        end
        if (g.wen == 1) begin
            vectors++;
            if (last_wdata !== g.wdata) begin
                errors++;
                $display("FAIL %s ram_wdata: got %h, required %h", name, last_wdata, g.wdata);
            end
        end
        i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; ram_busy = 1'b0;
    endtask

    task automatic check_word(input int idx, input string name);
        vectors++;
        if (mem[idx] !== gold[idx]) begin
            errors++;
            $display("FAIL %s mem[%0d]: got %h, required %h", name, idx, mem[idx], gold[idx]);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (i_rdata !== NOP) begin
            errors++; $display("FAIL reset i_rdata: got %h, required %h", i_rdata, NOP);
        end
        vectors++;
        if (d_rdata !== 32'h0 || fault !== 1'b0) begin
            errors++; $display("FAIL reset d_rdata/fault: got %h/%b, required 0/0", d_rdata, fault);
        end
        vectors++;
        if (ram_wen !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL reset ram_wen/stall: got %b/%b, required 0/0", ram_wen, stall);
        end
        @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic test_fetch();
        do_tx(1, 32'h8, 0, 0, 32'h0, 32'h0, 2'b10, 0, 0, "fetch_only");
        do_tx(1, 32'h4, 0, 0, 32'h0, 32'h0, 2'b10, 0, 0, "fetch_w1");
    endtask

    task automatic test_load();
        do_tx(0, 32'h0, 1, 0, 32'h6, 32'h0, 2'b00, 0, 0, "lb_signed");
        do_tx(0, 32'h0, 1, 0, 32'h6, 32'h0, 2'b00, 1, 0, "lb_unsigned");
        do_tx(1, 32'h8, 1, 0, 32'h4, 32'h0, 2'b01, 0, 0, "lh_signed_fetch");
        do_tx(1, 32'hC, 1, 0, 32'h6, 32'h0, 2'b01, 1, 0, "lh_unsigned_fetch");
        do_tx(1, 32'h0, 1, 0, 32'hC, 32'h0, 2'b10, 0, 0, "lw_fetch");
    endtask

    task automatic test_rmw();
        do_tx(1, 32'h8, 0, 1, 32'hE, 32'h0000_BEEF, 2'b01, 0, 0, "sh_rmw");
        check_word(3, "sh_rmw");
        do_tx(0, 32'h0, 0, 1, 32'h11, 32'hFFFF_FF5A, 2'b00, 0, 0, "sb_rmw");
        check_word(4, "sb_rmw");
    endtask

    task automatic test_fault();
        do_tx(0, 32'h0, 0, 1, 32'h5, 32'h1234_5678, 2'b10, 0, 0, "sw_misaligned");
        check_word(1, "sw_misaligned");
        do_tx(1, 32'h8, 1, 0, 32'h8, 32'h0, 2'b11, 0, 0, "reserved_size");
        do_tx(0, 32'h0, 0, 1, 32'h3, 32'h0000_AAAA, 2'b01, 0, 0, "sh_misaligned");
        do_tx(1, 32'h4, 1, 0, 32'h400, 32'h0, 2'b10, 0, 0, "out_of_range");
        do_tx(0, 32'h0, 1, 0, 32'h3FC, 32'h0, 2'b10, 0, 0, "last_word_ok");
    endtask

    task automatic test_busy();
        do_tx(0, 32'h0, 0, 1, 32'h14, 32'hDEAD_BEEF, 2'b10, 0, 3, "sw_busy");
        check_word(5, "sw_busy");
        do_tx(1, 32'h14, 0, 1, 32'h1A, 32'h0000_77AA, 2'b01, 0, 2, "sh_busy_fetch");
        check_word(6, "sh_busy_fetch");
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int k = 0; k < 10; k++) begin
            sz = 2'($urandom_range(0, 2));
            a  = 32'h20 + 32'($urandom_range(0, 31));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            do_tx(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                  k[0], ~k[0], a, $urandom, sz, 1'($urandom_range(0, 1)), 0, "back_to_back");
        end
        for (int j = 8; j < 16; j++) check_word(j, "back_to_back");
    endtask

    task automatic test_reset_rmw();
        int w0;
        @(negedge clk);
        w0 = wen_any;
        i_req = 1'b1; i_addr = 32'h0; d_wen = 1'b1; d_ren = 1'b0;
        d_addr = 32'h10; d_size = 2'b01; d_wdata = 32'h0000_CAFE;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (ram_wen !== 1'b1) begin
            errors++; $display("FAIL reset_rmw pre_wen: got %b, required 1", ram_wen);
        end
        nRst = 1'b0;
        #1;
        vectors++;
        if (ram_wen !== 1'b0) begin
            errors++; $display("FAIL reset_rmw ram_wen: got %b, required 0", ram_wen);
        end
        vectors++;
        if (i_rdata !== NOP || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rmw regs: got %h/%h, required %h/0", i_rdata, d_rdata, NOP);
        end
        i_req = 1'b0; d_wen = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (wen_any !== w0) begin
            errors++; $display("FAIL reset_rmw write_count: got %0d, required %0d", wen_any - w0, 0);
        end
        check_word(4, "reset_rmw");
        exp_i = NOP;
        exp_d = 32'h0;
        do_tx(1, 32'h8, 0, 0, 32'h0, 32'h0, 2'b10, 0, 0, "after_reset_fetch");
    endtask

    initial begin
        vectors = 0; errors = 0; wen_any = 0; wen_ok = 0; last_wdata = 32'h0;
        nRst = 1'b0; ram_busy = 1'b0;
        i_req = 1'b0; i_addr = 32'h0; d_ren = 1'b0; d_wen = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; d_size = 2'b00; d_unsigned = 1'b0;
        exp_i = NOP; exp_d = 32'h0;
        for (int i = 0; i < 256; i++) gold[i] = 32'h1357_0000 + 32'(i) * 32'h0001_0203;
        gold[1] = 32'h8899_AABB;
        gold[2] = 32'h0050_0093;
        gold[3] = 32'h1122_3344;
        gold[4] = 32'hA1B2_C3D4;
        pl_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_idx = 8'(i);
            pl_val = gold[i];
        end
        @(negedge clk);
        pl_en = 1'b0;
        test_reset();
        test_fetch();
        test_load();
        test_rmw();
        test_fault();
        test_busy();
        test_back_to_back();
        test_reset_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ru_mem_ctrl.md
Name: ru_mem_ctrl

Overview:
- Memory request sequencer between the single-cycle core and the single-ported word RAM (ru_ram).
- Serialises instruction fetch and data load/store onto the one RAM port and stalls the core until both complete.
- Performs byte/halfword stores as read-modify-write and sign/zero-extends sub-word loads.
- Honours the RAM busy signal on every RAM cycle.

Parameters:
MEM_WORDS, 256, number of 32-bit words in the RAM; word index = addr[31:2]; index >= MEM_WORDS is a fault.
NOP_INSTR, 32'h0000_0013, value of i_rdata after reset (addi x0,x0,0).

Ports:
clk  input  1  clock, all state on rising edge
nRst  input  1  asynchronous active-low reset
i_req  input  1  core requests instruction fetch
i_addr  input  32  fetch byte address (word aligned)
i_rdata  output  32  fetched instruction, registered
d_ren  input  1  core load request
d_wen  input  1  core store request (d_wen has priority if both set)
d_addr  input  32  data byte address
d_wdata  input  32  store data, right-aligned
d_size  input  2  00 byte, 01 half, 10 word, 11 reserved
d_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
d_rdata  output  32  load result, registered, extended
stall  output  1  core must hold all request inputs stable while 1
fault  output  1  misaligned/out-of-range/reserved-size data access, valid in DONE
ram_addr  output  32  byte address to RAM (always word aligned, addr[1:0]=0)
ram_wen  output  1  RAM write enable
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM combinational read data
ram_busy  input  1  RAM not ready; current RAM cycle repeats

Behaviour:
- Reset (async, nRst=0): state IDLE, i_rdata=NOP_INSTR, d_rdata=0, fault=0, merge reg=0; ram_wen=0 immediately. Reset mid-transaction aborts it; no write is issued after reset is released.
- States:
  - IDLE: stall = i_req|d_ren|d_wen. Valid data request -> DACC; faulting data request -> fault_q set, d_rdata_q=0, then IFETCH if i_req else DONE; only i_req -> IFETCH; nothing -> stay.
  - DACC: ram_addr={d_addr[31:2],2'b00}. On ram_busy=1 hold state, ram_wen=0.
    - Word store: ram_wen=1, ram_wdata=d_wdata; -> IFETCH if i_req else DONE.
    - Sub-word store: capture ram_rdata into merge reg -> RMW.
    - Load: capture extracted and extended lane into d_rdata; -> IFETCH if i_req else DONE.
  - RMW: ram_wen=1, ram_wdata = merge reg with lane replaced; held while ram_busy; then -> IFETCH if i_req else DONE.
  - IFETCH: ram_addr=i_addr, ram_wen=0; when !ram_busy capture ram_rdata into i_rdata -> DONE.
  - DONE: stall=0, fault valid; -> IDLE. The core advances on this edge.
- Stall is 1 in all states except DONE, and in IDLE when no request is present.
- Lanes: byte lane = d_addr[1:0], bits [8*lane+7:8*lane]; half lane = d_addr[1], bits [16*h+15:16*h]. Stores take d_wdata[7:0] or [15:0].
- Fault conditions: half with addr[0]=1; word with addr[1:0]!=0; d_size=11; word index >= MEM_WORDS. On fault, no RAM access occurs and memory is unchanged.
- Latency, zero busy: fetch only 3 cycles (IDLE, IFETCH, DONE); load or word store + fetch 4; sub-word store + fetch 5. Each busy cycle adds 1.
- ram_wen is asserted for exactly one non-busy cycle per store.

Optional Feature:
RU_MEMCTRL_PERF_EN:
- Defined: adds output ports perf_stall_cnt[31:0], which counts cycles with stall=1, and perf_rmw_cnt[15:0], which counts completed RMW writes. Both counters saturate, not wrap, and reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Fetch only: i_req=1, i_addr=0x8, RAM word2=0x00500093 -> stall high 2 cycles, i_rdata=0x00500093 in DONE, fault=0.
- Signed byte load: word1=0x8899AABB, d_ren, d_addr=0x6, d_size=00, d_unsigned=0 -> d_rdata=0xFFFFFF99; with d_unsigned=1 -> 0x00000099.
- Halfword store RMW: word3=0x11223344, d_wen, d_addr=0xE, d_size=01, d_wdata=0xBEEF -> one ram_wen pulse with ram_wdata=0xBEEF3344; total stall 4 cycles with i_req.
- Misaligned word store: d_addr=0x5, d_size=10 -> fault=1 in DONE, ram_wen never asserted, word1 unchanged.
- Busy insertion: ram_busy=1 for 2 cycles during DACC of a word store 0xDEADBEEF -> ram_wen high only on the non-busy cycle, stall extended by 2.
- Reset in RMW state: nRst=0 -> ram_wen=0 immediately, i_rdata=0x00000013, memory word unchanged.
